dds_nco_multich: RTL and testbench

//  Multi-channel DDS phase-accumulator/NCO address generator; next generation of our single-channel DDS address block.
//  One shared accumulator drives N_CH ROM addresses with per-channel phase offsets.

---
 rtl/dds_pkg.sv | 22 ++
 rtl/dds_sweep_ctrl.sv | 114 +++++++++++
 rtl/dds_nco_multich.sv | 164 ++++++++++++++++
 tb/tb_dds_nco_multich.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types and helpers for the multi-channel DDS address generator.
// Contents:
//   DEF_ACC_W / DEF_ADDR_W - default accumulator and ROM address widths
//   sweep_state_t          - frequency sweep controller states
//   ch_lsb()               - low bit index of a channel inside a packed bus
package dds_pkg;

    localparam int DEF_ACC_W  = 32;
    localparam int DEF_ADDR_W = 12;

    typedef enum logic [1:0] {
        SWEEP_IDLE = 2'd0,
        SWEEP_RUN  = 2'd1,
        SWEEP_DONE = 2'd2
    } sweep_state_t;

    // Channel k of a packed bus of width-bit fields starts at bit k*width.
    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep engine for the DDS.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   sweep_start   - pulse, start a sweep from fword_shadow (only when idle)
//   sweep_abort   - pulse, stop a running sweep, active word is held
//   fword_shadow  - shadow frequency word (sweep start value)
//   fword_act     - currently active frequency word (sweep base for each step)
//   sweep_step    - increment applied every SWEEP_DIV clocks
//   sweep_limit   - final frequency word
//   load/load_val - request to load load_val into the active frequency word
//   busy          - sweep running
//   done          - one-cycle pulse when the limit has been reached
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int ACC_W     = DEF_ACC_W,
    parameter int SWEEP_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sweep_start,
    input  logic             sweep_abort,
    input  logic [ACC_W-1:0] fword_shadow,
    input  logic [ACC_W-1:0] fword_act,
    input  logic [ACC_W-1:0] sweep_step,
    input  logic [ACC_W-1:0] sweep_limit,
    output logic             load,
    output logic [ACC_W-1:0] load_val,
    output logic             busy,
    output logic             done
);

    localparam int DIV_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SWEEP_DIV - 1);

    sweep_state_t     state_r;
    sweep_state_t     state_nxt_s;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_nxt_s;
    logic [ACC_W:0]   sum_s;
    logic             busy_r;
    logic             done_r;

    // Sum is one bit wider so that crossing the limit can never alias through a wrap.
    assign sum_s = {1'b0, fword_act} + {1'b0, sweep_step};

    // Next-state, divider and active-word load decisions.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        load        = 1'b0;
        load_val    = '0;
        case (state_r)
            SWEEP_IDLE: begin
                if (sweep_start) begin
                    load      = 1'b1;
                    cnt_nxt_s = '0;
                    if (fword_shadow >= sweep_limit) begin
                        load_val    = sweep_limit;
                        state_nxt_s = SWEEP_DONE;
                    end else begin
                        load_val    = fword_shadow;
                        state_nxt_s = SWEEP_RUN;
                    end
                end else begin
                    state_nxt_s = SWEEP_IDLE;
                end
            end
            SWEEP_RUN: begin
                if (sweep_abort) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = SWEEP_IDLE;
                end else if (cnt_r == DIV_LAST) begin
                    cnt_nxt_s = '0;
                    load      = 1'b1;
                    if (sum_s >= {1'b0, sweep_limit}) begin
                        load_val    = sweep_limit;
                        state_nxt_s = SWEEP_DONE;
                    end else begin
                        load_val = sum_s[ACC_W-1:0];
                    end
                end else begin
                    cnt_nxt_s = cnt_r + DIV_W'(1);
                end
            end
            SWEEP_DONE: begin
                state_nxt_s = SWEEP_IDLE;
            end
            default: begin
                state_nxt_s = SWEEP_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, divider and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SWEEP_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == SWEEP_RUN);
            done_r  <= (state_nxt_s == SWEEP_DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: rtl/dds_nco_multich.sv
// Multi-channel DDS phase accumulator / NCO ROM address generator.
// One shared accumulator feeds N_CH ROM addresses, each with its own phase offset.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   fword_in/fword_we       - frequency word into the shadow register
//   pword_in/pword_ch/pword_we - phase offset into the shadow of one channel
//   update                  - copy all shadows to the active words (ignored while sweeping)
//   sync_clr                - clear the accumulator
//   match_addr              - compare value for match_strobe
//   sweep_step/sweep_limit/sweep_start/sweep_abort - frequency sweep control
//   addr_out                - channel k address at [k*ADDR_W +: ADDR_W]
//   wrap_strobe             - marks the first sample after accumulator overflow
//   match_strobe            - addr_out[k] equals match_addr
//   sweep_busy/sweep_done   - sweep status
module dds_nco_multich
    import dds_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int SWEEP_DIV = 1,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ACC_W-1:0]         fword_in,
    input  logic                     fword_we,
    input  logic [ADDR_W-1:0]        pword_in,
    input  logic [CH_W-1:0]          pword_ch,
    input  logic                     pword_we,
    input  logic                     update,
    input  logic                     sync_clr,
    input  logic [ADDR_W-1:0]        match_addr,
    input  logic [ACC_W-1:0]         sweep_step,
    input  logic [ACC_W-1:0]         sweep_limit,
    input  logic                     sweep_start,
    input  logic                     sweep_abort,
    output logic [N_CH*ADDR_W-1:0]   addr_out,
    output logic [N_CH-1:0]          wrap_strobe,
    output logic [N_CH-1:0]          match_strobe,
    output logic                     sweep_busy,
    output logic                     sweep_done
);

    logic [ACC_W-1:0]  fword_sh_r;
    logic [ACC_W-1:0]  fword_act_r;
    logic [ADDR_W-1:0] pword_sh_r  [N_CH];
    logic [ADDR_W-1:0] pword_act_r [N_CH];
    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W:0]    acc_sum_s;
    logic              carry_r;
    logic [N_CH-1:0]   wrap_r;
    logic              commit_s;
    logic              pword_ok_s;
    logic              sweep_load_s;
    logic [ACC_W-1:0]  sweep_val_s;

    dds_sweep_ctrl #(
        .ACC_W     (ACC_W),
        .SWEEP_DIV (SWEEP_DIV)
    ) u_sweep (
        .clk          (clk),
        .rst_n        (rst_n),
        .sweep_start  (sweep_start),
        .sweep_abort  (sweep_abort),
        .fword_shadow (fword_sh_r),
        .fword_act    (fword_act_r),
        .sweep_step   (sweep_step),
        .sweep_limit  (sweep_limit),
        .load         (sweep_load_s),
        .load_val     (sweep_val_s),
        .busy         (sweep_busy),
        .done         (sweep_done)
    );

    // A running sweep owns the active words; update is dropped until it finishes.
    assign commit_s   = update & ~sweep_busy;
    assign pword_ok_s = ({1'b0, pword_ch} < (CH_W + 1)'(N_CH));
    assign acc_sum_s  = {1'b0, acc_r} + {1'b0, fword_act_r};

    // Shadow registers: written by the control interface, never seen by the datapath directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fword_sh_r <= '0;
            for (int k = 0; k < N_CH; k++) begin
                pword_sh_r[k] <= '0;
            end
        end else begin
            if (fword_we) begin
                fword_sh_r <= fword_in;
            end
            if (pword_we && pword_ok_s) begin
                pword_sh_r[pword_ch] <= pword_in;
            end
        end
    end

    // Active words: sweep loads take priority, otherwise all shadows commit together on update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fword_act_r <= '0;
            for (int k = 0; k < N_CH; k++) begin
                pword_act_r[k] <= '0;
            end
        end else begin
            if (sweep_load_s) begin
                fword_act_r <= sweep_val_s;
            end else if (commit_s) begin
                fword_act_r <= fword_sh_r;
            end
            if (commit_s) begin
                for (int k = 0; k < N_CH; k++) begin
                    pword_act_r[k] <= pword_sh_r[k];
                end
            end
        end
    end

    // Phase accumulator; the carry is staged twice so wrap lines up with the first post-overflow address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= '0;
            carry_r <= 1'b0;
            wrap_r  <= '0;
        end else begin
            if (sync_clr) begin
                acc_r   <= '0;
                carry_r <= 1'b0;
            end else begin
                acc_r   <= acc_sum_s[ACC_W-1:0];
                carry_r <= acc_sum_s[ACC_W];
            end
            wrap_r <= {N_CH{carry_r}};
        end
    end

    assign wrap_strobe = wrap_r;

    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_ch
            logic [ADDR_W-1:0] addr_nxt_s;
            logic [ADDR_W-1:0] addr_r;
            logic              match_r;

            assign addr_nxt_s = acc_r[ACC_W-1 -: ADDR_W] + pword_act_r[k];

            // Per-channel address and match flag, registered together so they stay aligned.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    addr_r  <= '0;
                    match_r <= 1'b0;
                end else begin
                    addr_r  <= addr_nxt_s;
                    match_r <= (addr_nxt_s == match_addr);
                end
            end

            assign addr_out[ch_lsb(k, ADDR_W) +: ADDR_W] = addr_r;
            assign match_strobe[k] = match_r;
        end
    endgenerate

endmodule

// File: tb/tb_dds_nco_multich.sv
// Self-checking bench for dds_nco_multich (N_CH=2, ACC_W=32, ADDR_W=12, SWEEP_DIV=4).
// A cycle-level reference model derived from the behavioural rules predicts every output.
module tb_dds_nco_multich;

    localparam int N_CH   = 2;
    localparam int ACC_W  = 32;
    localparam int ADDR_W = 12;
    localparam int SDIV   = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [ACC_W-1:0]       fword_in;
    logic                   fword_we;
    logic [ADDR_W-1:0]      pword_in;
    logic [0:0]             pword_ch;
    logic                   pword_we;
    logic                   update;
    logic                   sync_clr;
    logic [ADDR_W-1:0]      match_addr;
    logic [ACC_W-1:0]       sweep_step;
    logic [ACC_W-1:0]       sweep_limit;
    logic                   sweep_start;
    logic                   sweep_abort;
    logic [N_CH*ADDR_W-1:0] addr_out;
    logic [N_CH-1:0]        wrap_strobe;
    logic [N_CH-1:0]        match_strobe;
    logic                   sweep_busy;
    logic                   sweep_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dds_nco_multich #(
        .N_CH(N_CH), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .SWEEP_DIV(SDIV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fword_in(fword_in), .fword_we(fword_we),
        .pword_in(pword_in), .pword_ch(pword_ch), .pword_we(pword_we),
        .update(update), .sync_clr(sync_clr), .match_addr(match_addr),
        .sweep_step(sweep_step), .sweep_limit(sweep_limit),
        .sweep_start(sweep_start), .sweep_abort(sweep_abort),
        .addr_out(addr_out), .wrap_strobe(wrap_strobe), .match_strobe(match_strobe),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_acc, m_fsh, m_fact;
    logic [11:0] m_psh [2];
    logic [11:0] m_pact [2];
    logic [11:0] m_addr [2];
    logic [1:0]  m_wrap, m_match;
    logic        m_wrap_pend;
    int          m_st;        // 0 idle, 1 running, 2 done
    int          m_run_cyc;   // clocks spent running since the sweep started

    task automatic model_reset();
        m_acc = 32'd0; m_fsh = 32'd0; m_fact = 32'd0;
        for (int i = 0; i < 2; i++) begin
            m_psh[i] = 12'd0; m_pact[i] = 12'd0; m_addr[i] = 12'd0;
        end
        m_wrap = 2'b00; m_match = 2'b00; m_wrap_pend = 1'b0;
        m_st = 0; m_run_cyc = 0;
    endtask

    // One clock edge worth of behaviour, using the inputs present at the edge.
    task automatic model_step();
        longint      s, t;
        logic [31:0] n_fact;
        logic [11:0] n_pact [2];
        int          n_st;
        bit          commit;
        s = longint'(m_acc) + longint'(m_fact);
        for (int i = 0; i < 2; i++) begin
            m_addr[i]  = 12'((m_acc >> 20) + 32'(m_pact[i]));
            m_match[i] = (m_addr[i] == match_addr);
        end
        m_wrap      = {2{m_wrap_pend}};
        m_wrap_pend = !sync_clr && (s >= 64'sh1_0000_0000);
        m_acc       = sync_clr ? 32'd0 : 32'(s);

        commit = update && (m_st != 1);
        n_fact = commit ? m_fsh : m_fact;
        for (int i = 0; i < 2; i++) n_pact[i] = commit ? m_psh[i] : m_pact[i];
        n_st = m_st;
        if (m_st == 0) begin
            if (sweep_start) begin
                if (m_fsh >= sweep_limit) begin
                    n_fact = sweep_limit; n_st = 2;
                end else begin
                    n_fact = m_fsh; n_st = 1; m_run_cyc = 0;
                end
            end
        end else if (m_st == 1) begin
            if (sweep_abort) begin
                n_st = 0;
            end else begin
                m_run_cyc++;
                if (m_run_cyc % SDIV == 0) begin
                    t = longint'(m_fact) + longint'(sweep_step);
                    if (t >= longint'(sweep_limit)) begin
                        n_fact = sweep_limit; n_st = 2;
                    end else begin
                        n_fact = 32'(t);
                    end
                end
            end
        end else begin
            n_st = 0;
        end
        m_fact = n_fact;
        for (int i = 0; i < 2; i++) m_pact[i] = n_pact[i];
        m_st = n_st;

        if (fword_we) m_fsh = fword_in;
        if (pword_we) m_psh[pword_ch] = pword_in;
    endtask

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("addr0", 64'(addr_out[11:0]), 64'(m_addr[0]));
        check_val("addr1", 64'(addr_out[23:12]), 64'(m_addr[1]));
        check_val("wrap", 64'(wrap_strobe), 64'(m_wrap));
        check_val("match", 64'(match_strobe), 64'(m_match));
        check_val("busy", 64'(sweep_busy), 64'(m_st == 1));
        check_val("done", 64'(sweep_done), 64'(m_st == 2));
        check_val("fword_act", 64'(dut.fword_act_r), 64'(m_fact));
    endtask

    task automatic clear_pulses();
        fword_we = 1'b0; pword_we = 1'b0; update = 1'b0; sync_clr = 1'b0;
        sweep_start = 1'b0; sweep_abort = 1'b0;
    endtask

    // Clock edge, model, check #1 later, then drop single-cycle pulses.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        clear_pulses();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [11:0] prev_a;

    initial begin
        rst_n = 1'b0;
        fword_in = 32'd0; pword_in = 12'd0; pword_ch = 1'b0; match_addr = 12'd0;
        sweep_step = 32'd0; sweep_limit = 32'd0;
        clear_pulses();
        model_reset();
        #12;
        check_all();
        #1 rst_n = 1'b1;

        // Constant tuning word: 16 address steps per clock.
        fword_in = 32'h0100_0000; fword_we = 1'b1; tick();
        update = 1'b1; tick();
        ticks(2);
        check_val("first_addr", 64'(addr_out[11:0]), 64'h10);
        for (int i = 0; i < 4; i++) begin
            prev_a = addr_out[11:0];
            tick();
            check_val("step16", 64'(addr_out[11:0]), 64'(12'(prev_a + 12'd16)));
        end

        // Half-rate word: 0x000/0x800 alternation with wrap strobes.
        fword_in = 32'h8000_0000; fword_we = 1'b1; tick();
        update = 1'b1; sync_clr = 1'b1; tick();
        ticks(6);
        prev_a = addr_out[11:0];
        tick();
        check_val("alternate", 64'(addr_out[11:0] ^ prev_a), 64'h800);

        // Phase offsets and match strobe.
        match_addr = 12'hC00;
        pword_in = 12'h400; pword_ch = 1'b1; pword_we = 1'b1; tick();
        pword_in = 12'h000; pword_ch = 1'b0; pword_we = 1'b1; tick();
        update = 1'b1; tick();
        ticks(4);
        check_val("ch1_offset", 64'(addr_out[23:12]), 64'(12'(addr_out[11:0] + 12'h400)));

        // Shadow write in the update cycle keeps the old word active.
        fword_in = 32'h0010_0000; fword_we = 1'b1; update = 1'b1; tick();
        ticks(3);
        update = 1'b1; sync_clr = 1'b1; tick();
        ticks(4);

        // Sweep 0x100 -> 0x400 in 0x100 steps, one step per 4 clocks.
        fword_in = 32'h100; fword_we = 1'b1; sweep_step = 32'h100; sweep_limit = 32'h400; tick();
        sweep_start = 1'b1; tick();
        check_val("sweep_first", 64'(dut.fword_act_r), 64'h100);
        ticks(12);
        check_val("sweep_limit", 64'(dut.fword_act_r), 64'h400);
        check_val("sweep_done_pulse", 64'(sweep_done), 64'h1);
        ticks(3);

        // Abort mid-run holds the active word.
        sweep_step = 32'h10; sweep_limit = 32'h0001_0000; sweep_start = 1'b1; tick();
        ticks(9);
        sweep_abort = 1'b1; update = 1'b1; tick();
        ticks(3);

        // Start with shadow already past the limit.
        sweep_limit = 32'h80; sweep_start = 1'b1; tick();
        ticks(3);

        // Asynchronous reset during a run.
        sweep_limit = 32'hFFFF_0000; sweep_start = 1'b1; tick();
        ticks(5);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst_n = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                fword_we = 1'b1;
                case ($urandom_range(0, 3))
                    0: fword_in = 32'h0100_0000;
                    1: fword_in = 32'h8000_0000;
                    2: fword_in = $urandom & 32'hFFF0_0000;
                    default: fword_in = $urandom;
                endcase
            end
            if ($urandom_range(0, 3) == 0) begin
                pword_we = 1'b1;
                pword_ch = 1'($urandom);
                pword_in = 12'($urandom);
            end
            update   = ($urandom_range(0, 5) == 0);
            sync_clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) match_addr = 12'($urandom) & 12'hFF0;
            if ($urandom_range(0, 49) == 0) begin
                sweep_step  = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom & 32'h00FF_FFFF);
                sweep_limit = $urandom;
            end
            sweep_start = ($urandom_range(0, 24) == 0);
            sweep_abort = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
